// File: rtl/coin_pkg.sv
// Shared types and geometry for the coin animation controller.
// Sprite box size and spin-frame count are fixed here because the ROM address width depends on them.
package coin_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SPIN = 2'd1,
        ST_POP  = 2'd2,
        ST_DONE = 2'd3
    } coin_state_t;

    localparam int SPRITE_W        = 20;
    localparam int SPRITE_H        = 20;
    localparam int NUM_SPIN_FRAMES = 4;

    localparam int COORD_W = 10;
    localparam int DIFF_W  = COORD_W + 1;
    localparam int ADDR_W  = $clog2(SPRITE_W * SPRITE_H);
    localparam int SEL_W   = $clog2(NUM_SPIN_FRAMES);
    localparam int POP_W   = 5;
    localparam int OFF_W   = 5;

endpackage

// File: rtl/coin_addr_gen.sv
// Combinational sprite-box hit test and ROM address for the coin, including the pop rise offset.
// Differences are 11-bit signed so pixels left of / above the box come out negative.
module coin_addr_gen
    import coin_pkg::*;
(
    input  logic [COORD_W-1:0] i_coin_x,
    input  logic [COORD_W-1:0] i_coin_y,
    input  logic [COORD_W-1:0] i_draw_x,
    input  logic [COORD_W-1:0] i_draw_y,
    input  logic [POP_W-1:0]   i_pop_offset,
    output logic               o_in_box,
    output logic [ADDR_W-1:0]  o_addr
);

    localparam logic signed [DIFF_W-1:0] W_LIM = DIFF_W'(SPRITE_W);
    localparam logic signed [DIFF_W-1:0] H_LIM = DIFF_W'(SPRITE_H);

    logic signed [DIFF_W-1:0] w_y_eff;
    logic signed [DIFF_W-1:0] w_dx;
    logic signed [DIFF_W-1:0] w_dy;
    logic [ADDR_W-1:0]        w_prod;

    assign w_y_eff = $signed({1'b0, i_coin_y}) - $signed({{(DIFF_W-POP_W){1'b0}}, i_pop_offset});
    assign w_dx    = $signed({1'b0, i_draw_x}) - $signed({1'b0, i_coin_x});
    assign w_dy    = $signed({1'b0, i_draw_y}) - w_y_eff;

    assign o_in_box = (w_dx >= 0) && (w_dx < W_LIM) && (w_dy >= 0) && (w_dy < H_LIM);

    // Inside the box both offsets are below 20, so the low bits carry the full value.
    assign w_prod = ADDR_W'(w_dy[OFF_W-1:0]) * ADDR_W'(SPRITE_W) + ADDR_W'(w_dx[OFF_W-1:0]);
    assign o_addr = o_in_box ? w_prod : '0;

endmodule

// File: rtl/coin_anim_ctrl.sv
// Coin sprite controller: spins while present, rises for POP_STEPS frames when collected, then waits for removal.
// Address, hit and frame select are registered so the pixel pipeline sees one clock of latency.
module coin_anim_ctrl
    import coin_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 8,
    parameter int POP_STEPS       = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_frame_start,
    input  logic               i_enable,
    input  logic               i_collect,
    input  logic [COORD_W-1:0] i_coin_x,
    input  logic [COORD_W-1:0] i_coin_y,
    input  logic [COORD_W-1:0] i_draw_x,
    input  logic [COORD_W-1:0] i_draw_y,
    output logic [ADDR_W-1:0]  o_read_address,
    output logic [SEL_W-1:0]   o_frame_sel,
    output logic               o_pixel_hit,
    output logic               o_busy,
    output logic               o_done
);

    localparam int STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);
    localparam logic [POP_W-1:0]  POP_MAX   = POP_W'(POP_STEPS);

    coin_state_t       r_state;
    coin_state_t       w_state_n;
    logic [STEP_W-1:0] r_step;
    logic [STEP_W-1:0] w_step_n;
    logic [POP_W-1:0]  r_pop;
    logic [POP_W-1:0]  w_pop_n;
    logic [SEL_W-1:0]  r_frame_sel;
    logic [SEL_W-1:0]  w_frame_sel_n;
    logic [ADDR_W-1:0] r_read_address;
    logic              r_pixel_hit;
    logic              w_in_box;
    logic [ADDR_W-1:0] w_addr;
    logic              w_visible;

    coin_addr_gen u_addr_gen (
        .i_coin_x     (i_coin_x),
        .i_coin_y     (i_coin_y),
        .i_draw_x     (i_draw_x),
        .i_draw_y     (i_draw_y),
        .i_pop_offset (r_pop),
        .o_in_box     (w_in_box),
        .o_addr       (w_addr)
    );

    assign w_visible = (r_state == ST_SPIN) || (r_state == ST_POP);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_step         <= '0;
            r_pop          <= '0;
            r_frame_sel    <= '0;
            r_read_address <= '0;
            r_pixel_hit    <= 1'b0;
        end else begin
            r_state        <= w_state_n;
            r_step         <= w_step_n;
            r_pop          <= w_pop_n;
            r_frame_sel    <= w_frame_sel_n;
            r_read_address <= w_addr;
            r_pixel_hit    <= w_in_box && w_visible;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_step_n      = r_step;
        w_pop_n       = r_pop;
        w_frame_sel_n = r_frame_sel;
        case (r_state)
            ST_IDLE: begin
                if (i_enable) begin
                    w_state_n     = ST_SPIN;
                    w_step_n      = '0;
                    w_frame_sel_n = '0;
                end
            end
            ST_SPIN: begin
                // Losing the coin outranks a touch; a touch swallows any frame_start in the same cycle.
                if (!i_enable) begin
                    w_state_n = ST_IDLE;
                end else if (i_collect) begin
                    w_state_n = ST_POP;
                    w_step_n  = '0;
                    w_pop_n   = '0;
                end else if (i_frame_start) begin
                    if (r_step == STEP_LAST) begin
                        w_step_n      = '0;
                        w_frame_sel_n = r_frame_sel + SEL_W'(1);
                    end else begin
                        w_step_n = r_step + STEP_W'(1);
                    end
                end
            end
            ST_POP: begin
                if (i_frame_start) begin
                    w_frame_sel_n = r_frame_sel + SEL_W'(1);
                    w_pop_n       = (r_pop == POP_MAX) ? r_pop : r_pop + POP_W'(1);
                    if (w_pop_n == POP_MAX) begin
                        w_state_n = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!i_enable) begin
                    w_state_n = ST_IDLE;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    assign o_read_address = r_read_address;
    assign o_frame_sel    = r_frame_sel;
    assign o_pixel_hit    = r_pixel_hit;
    assign o_busy         = (r_state == ST_POP);
    assign o_done         = (r_state == ST_DONE);

endmodule

// File: tb/tb_coin_anim_ctrl.sv
// Directed plus randomized bench for coin_anim_ctrl against a frame-counting reference model.
// The model tracks total frames seen and pop height as plain integers, not a copy of the RTL.
module tb_coin_anim_ctrl;

    localparam int FPS  = 8;
    localparam int POPN = 16;
    localparam int SW   = 20;
    localparam int SH   = 20;

    localparam int M_IDLE = 0;
    localparam int M_SPIN = 1;
    localparam int M_POP  = 2;
    localparam int M_DONE = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fs = 1'b0;
    logic       en = 1'b0;
    logic       col = 1'b0;
    logic [9:0] coinX = 10'd0;
    logic [9:0] coinY = 10'd0;
    logic [9:0] drawX = 10'd0;
    logic [9:0] drawY = 10'd0;
    logic [8:0] readAddress;
    logic [1:0] frameSel;
    logic       pixelHit;
    logic       busy;
    logic       done;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    int mState = M_IDLE;
    int mSpinFrames = 0;
    int mSel = 0;
    int mPop = 0;
    int expAddr = 0;
    int expHit = 0;

    coin_anim_ctrl #(.FRAMES_PER_STEP(FPS), .POP_STEPS(POPN)) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_frame_start  (fs),
        .i_enable       (en),
        .i_collect      (col),
        .i_coin_x       (coinX),
        .i_coin_y       (coinY),
        .i_draw_x       (drawX),
        .i_draw_y       (drawY),
        .o_read_address (readAddress),
        .o_frame_sel    (frameSel),
        .o_pixel_hit    (pixelHit),
        .o_busy         (busy),
        .o_done         (done)
    );

    always #5 clk = ~clk;

    // Advance the reference by one clock using the inputs present at that edge.
    task automatic modelStep();
        int dx;
        int dy;
        bit inBox;
        if (rst) begin
            mState = M_IDLE;
            mSpinFrames = 0;
            mSel = 0;
            mPop = 0;
            expAddr = 0;
            expHit = 0;
            return;
        end
        dx = int'(drawX) - int'(coinX);
        dy = int'(drawY) - (int'(coinY) - mPop);
        inBox = (dx >= 0) && (dx < SW) && (dy >= 0) && (dy < SH);
        expAddr = inBox ? dy * SW + dx : 0;
        expHit = (inBox && (mState == M_SPIN || mState == M_POP)) ? 1 : 0;
        case (mState)
            M_IDLE: if (en) begin
                mState = M_SPIN;
                mSpinFrames = 0;
                mSel = 0;
            end
            M_SPIN: begin
                if (!en) mState = M_IDLE;
                else if (col) begin
                    mState = M_POP;
                    mSpinFrames = 0;
                    mPop = 0;
                end else if (fs) begin
                    mSpinFrames++;
                    if (mSpinFrames % FPS == 0) mSel = (mSel + 1) % 4;
                end
            end
            M_POP: if (fs) begin
                mSel = (mSel + 1) % 4;
                if (mPop < POPN) mPop++;
                if (mPop == POPN) mState = M_DONE;
            end
            default: if (!en) mState = M_IDLE;
        endcase
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic c, input logic f);
        rst = r;
        en = e;
        col = c;
        fs = f;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_addr"}, 32'(readAddress), 32'(expAddr));
        checkOutput({tag, "_hit"}, 32'(pixelHit), 32'(expHit));
        checkOutput({tag, "_sel"}, 32'(frameSel), 32'(mSel));
        checkOutput({tag, "_busy"}, 32'(busy), (mState == M_POP) ? 32'd1 : 32'd0);
        checkOutput({tag, "_done"}, 32'(done), (mState == M_DONE) ? 32'd1 : 32'd0);
    endtask

    task automatic framePulse(input logic e, input string tag);
        applyStimulus(1'b0, e, 1'b0, 1'b1);
        checkAll(tag);
        applyStimulus(1'b0, e, 1'b0, 1'b0);
        checkAll(tag);
    endtask

    initial begin
        coinX = 10'd100;
        coinY = 10'd200;
        drawX = 10'd0;
        drawY = 10'd0;

        // Reset with every other input active must still land in IDLE.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkAll("reset");
        checkOutput("reset_busy_const", 32'(busy), 32'd0);

        // Spin: frame_sel steps once per eight frame pulses, four steps wrap.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkAll("enter_spin");
        for (int i = 1; i <= 32; i++) begin
            framePulse(1'b1, "spin");
            if (i == 7) checkOutput("spin_sel_after7", 32'(frameSel), 32'd0);
            if (i == 8) checkOutput("spin_sel_after8", 32'(frameSel), 32'd1);
        end
        checkOutput("spin_sel_after32", 32'(frameSel), 32'd0);

        // Address and hit inside and outside the box.
        drawX = 10'd105;
        drawY = 10'd203;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkAll("addr_in");
        checkOutput("addr_in_const", 32'(readAddress), 32'd65);
        checkOutput("hit_in_const", 32'(pixelHit), 32'd1);
        drawX = 10'd120;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkAll("addr_out");
        checkOutput("hit_out_const", 32'(pixelHit), 32'd0);
        checkOutput("addr_out_const", 32'(readAddress), 32'd0);

        // Collect then sixteen frames of rise; enable drops mid-pop and is ignored.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkAll("collect");
        checkOutput("collect_busy_const", 32'(busy), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            framePulse((i < 10) ? 1'b1 : 1'b0, "pop");
            if (i < 16) checkOutput("pop_busy_const", 32'(busy), 32'd1);
            if (i == 5) begin
                coinY = 10'd200;
                drawX = 10'd100;
                drawY = 10'd195;
                applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
                checkAll("pop5_addr");
                checkOutput("pop5_addr_const", 32'(readAddress), 32'd0);
                checkOutput("pop5_hit_const", 32'(pixelHit), 32'd1);
            end
            if (i == 16) begin
                checkOutput("pop_done_const", 32'(done), 32'd0);
            end
        end
        // After the final pulse the cool-down cycle in framePulse has enable low, so DONE already left.
        checkOutput("done_left_const", 32'(done), 32'd0);
        checkOutput("done_left_busy_const", 32'(busy), 32'd0);

        // Same walk again with enable held high to see DONE hold, then release.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkAll("respin");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkAll("collect2");
        for (int i = 1; i <= 16; i++) framePulse(1'b1, "pop2");
        checkOutput("done_hold_const", 32'(done), 32'd1);
        checkOutput("done_hold_busy_const", 32'(busy), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkAll("done_exit");
        checkOutput("done_exit_const", 32'(done), 32'd0);

        // Collect and frame_start together: pop starts at 0 and frame_sel holds.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkAll("spin3");
        for (int i = 1; i <= 8; i++) framePulse(1'b1, "spin3");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        checkAll("collect_fs");
        checkOutput("collect_fs_sel_const", 32'(frameSel), 32'd1);
        checkOutput("collect_fs_busy_const", 32'(busy), 32'd1);
        coinX = 10'd100;
        coinY = 10'd200;
        drawX = 10'd100;
        drawY = 10'd200;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkAll("collect_fs_pop0");
        checkOutput("collect_fs_pop0_const", 32'(readAddress), 32'd0);
        checkOutput("collect_fs_hit_const", 32'(pixelHit), 32'd1);

        // Reset in the middle of a pop aborts it.
        for (int i = 1; i <= 7; i++) framePulse(1'b1, "pop3");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkAll("pop_reset");
        checkOutput("pop_reset_busy_const", 32'(busy), 32'd0);
        checkOutput("pop_reset_done_const", 32'(done), 32'd0);
        checkOutput("pop_reset_sel_const", 32'(frameSel), 32'd0);
        checkOutput("pop_reset_addr_const", 32'(readAddress), 32'd0);
        checkOutput("pop_reset_hit_const", 32'(pixelHit), 32'd0);

        // Randomized traffic with the pixel position mostly near the coin.
        for (int i = 0; i < 1500; i++) begin
            logic r;
            logic e;
            logic c;
            logic f;
            if (i % 200 == 0) begin
                coinX = 10'($urandom_range(0, 1023));
                coinY = 10'($urandom_range(0, 1023));
            end
            if ($urandom_range(0, 9) == 0) begin
                drawX = 10'($urandom_range(0, 1023));
                drawY = 10'($urandom_range(0, 1023));
            end else begin
                drawX = 10'(int'(coinX) + int'($urandom_range(0, 26)) - 3);
                drawY = 10'(int'(coinY) + int'($urandom_range(0, 56)) - 35);
            end
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 19) != 0);
            c = ($urandom_range(0, 29) == 0);
            f = ($urandom_range(0, 2) == 0);
            applyStimulus(r, e, c, f);
            checkAll("rand");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/coin_anim_ctrl.md
COIN_ANIM_CTRL -- requirements
Module: coin_anim_ctrl

Interface
REQ-001 Parameter FRAMES_PER_STEP, default 8: video frames per spin-frame advance in SPIN.
REQ-002 Parameter POP_STEPS, default 16: video frames of rise in POP; range 1..31.
REQ-003 Parameter SPRITE_W / SPRITE_H, default 20 / 20: sprite box size; SPRITE_W*SPRITE_H = 400 addresses.
REQ-004 Clk  in  1  system clock; one clock domain, all state on rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 frame_start  in  1  one-cycle pulse per video frame (vsync edge).
REQ-007 enable  in  1  coin present in level.
REQ-008 collect  in  1  one-cycle pulse: Mario touched coin.
REQ-009 coin_x, coin_y  in  10 each  top-left of coin box, screen pixels.
REQ-010 DrawX, DrawY  in  10 each  current pixel being drawn.
REQ-011 read_address  out  9  address to the selected coin_spin ROM.
REQ-012 frame_sel  out  2  which coin_spin ROM (0..3) drives the pixel.
REQ-013 pixel_hit  out  1  current pixel lies inside the visible coin box.
REQ-014 busy  out  1  high in POP; done  out  1  high in DONE.

Function
REQ-015 States SHALL be IDLE, SPIN, POP, DONE.
REQ-016 IDLE->SPIN when enable=1; SPIN->IDLE when enable=0; SPIN->POP on collect=1; POP->DONE on the frame_start that makes pop count equal POP_STEPS; DONE->IDLE when enable=0.
REQ-017 POP SHALL ignore enable and collect; collect in IDLE or DONE SHALL be ignored.
REQ-018 SPIN: step counter increments on each frame_start, wraps at FRAMES_PER_STEP-1 to 0; on wrap frame_sel advances 0->1->2->3->0.
REQ-019 POP: frame_sel advances on every frame_start; pop offset increments by 1 on every frame_start, saturating at POP_STEPS.
REQ-020 collect and frame_start in the same SPIN cycle: enter POP; that frame_start SHALL NOT advance pop offset or frame_sel.
REQ-021 Entering SPIN from IDLE SHALL clear step counter and frame_sel to 0; entering POP SHALL clear step counter and pop offset, keeping frame_sel.
REQ-022 Effective top y_eff = coin_y - pop_offset, computed 11-bit signed; dx = DrawX - coin_x, dy = DrawY - y_eff, 11-bit signed.
REQ-023 In-box iff 0<=dx<SPRITE_W and 0<=dy<SPRITE_H; pixel_hit = in-box AND state in {SPIN, POP}.
REQ-024 read_address = dy*SPRITE_W + dx when in-box, else 0; product SHALL NOT exceed 399.
REQ-025 read_address, frame_sel output, pixel_hit SHALL be registered: latency exactly 1 Clk from DrawX/DrawY/coin_x/coin_y to outputs.
REQ-026 busy, done SHALL be decoded from registered state (no input combinational path).
REQ-027 Palette transparency (index 0) is resolved downstream; this block SHALL NOT read ROM data.

Reset
REQ-028 Reset SHALL force state IDLE, step counter 0, pop offset 0, frame_sel 0, read_address 0, pixel_hit 0, busy 0, done 0 on the next Clk edge.
REQ-029 Reset mid-POP SHALL abort the pop; no done pulse issued.
REQ-030 Reset SHALL dominate every other input in the same cycle.

Structure
REQ-031 Package coin_pkg SHALL hold the state enum, SPRITE_W, SPRITE_H, NUM_SPIN_FRAMES=4.
REQ-032 Sub-module coin_addr_gen SHALL implement REQ-022..REQ-024 combinationally; the controller registers its outputs.

Verification
REQ-033 Reset, enable=1, 8 frame_start pulses -> frame_sel 0 then 1 after 8th pulse; 32 pulses -> back to 0.
REQ-034 coin_x=100, coin_y=200, DrawX=105, DrawY=203, SPIN -> next cycle read_address=65, pixel_hit=1; DrawX=120 -> pixel_hit=0, read_address=0.
REQ-035 collect in SPIN, then 16 frame_start -> busy=1 for 16 frames, done=1 after 16th; coin_y=200 at pop 5, DrawY=195, DrawX=100 -> read_address=0, pixel_hit=1.
REQ-036 collect and frame_start same cycle -> POP entered, pop offset 0, frame_sel unchanged.
REQ-037 Reset asserted at pop offset 7 -> next cycle IDLE, busy=0, done=0, all outputs 0.
REQ-038 enable=0 in POP -> stays POP until DONE; then enable=0 -> IDLE, done=0.
